// File: rtl/scalar_arb_pkg.sv
// scalar_arb_pkg: shared constants and types for the
// two-requester scalar memory arbiter.
package scalar_arb_pkg;

  localparam int NREQ     = 2;
  localparam int REQ_ID_W = 1;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    rd;
    req_id_t id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{rd: 1'b0, id: '0};

  // Round-robin choice: a lone eligible requester wins,
  // a tie goes to the favoured one.
  function automatic req_id_t rr_pick(
    input logic [NREQ-1:0] elig,
    input req_id_t         favour
  );
    if (elig[0] && elig[1]) return favour;
    return elig[1] ? req_id_t'(1) : req_id_t'(0);
  endfunction

endpackage

// File: rtl/scalar_arb_resp_fifo.sv
// scalar_arb_resp_fifo: show-ahead response FIFO with
// occupancy count; push and pop may coincide at any level.
module scalar_arb_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign valid = (cnt_q != '0);
  assign rdata = mem_q[rd_ptr_q];
  assign count = cnt_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Upstream credits keep this FIFO from ever overflowing.
  always_ff @(posedge clk) begin
    if (!srst) begin
      assert (!(push && !do_pop && cnt_q == FULL));
    end
  end

endmodule

// File: rtl/scalar_mem_arbiter.sv
// scalar_mem_arbiter: round-robin sharing of one scalar
// memory port, with credit-guarded per-requester read FIFOs.
module scalar_mem_arbiter
  import scalar_arb_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int RD_LATENCY = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              t0_valid,
  output logic              t0_ready,
  input  logic              t0_we,
  input  logic [3:0]        t0_mask,
  input  logic [AWIDTH-1:0] t0_addr,
  input  logic [31:0]       t0_data,
  input  logic              t1_valid,
  output logic              t1_ready,
  input  logic              t1_we,
  input  logic [3:0]        t1_mask,
  input  logic [AWIDTH-1:0] t1_addr,
  input  logic [31:0]       t1_data,
  output logic              i0_valid,
  input  logic              i0_ready,
  output logic [31:0]       i0_data,
  output logic              i1_valid,
  input  logic              i1_ready,
  output logic [31:0]       i1_data,
  output logic              m_t_valid,
  input  logic              m_t_ready,
  output logic              m_t_we,
  output logic [3:0]        m_t_mask,
  output logic [AWIDTH-1:0] m_t_addr,
  output logic [31:0]       m_t_data,
  input  logic              m_i_valid,
  input  logic [31:0]       m_i_data,
  output logic              err_orphan
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int WW = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(RESP_DEPTH);
  localparam logic [WW-1:0] WIN_INIT = WW'(RD_LATENCY);

  logic [NREQ-1:0] req_v, req_we, elig, grant;
  logic [NREQ-1:0] push, pop, rsp_v, rsp_rdy;
  logic [31:0]     rsp_d    [NREQ];
  logic [CW-1:0]   fifo_cnt [NREQ];
  logic [CW-1:0]   credit_q [NREQ];
  logic [CW-1:0]   credit_d [NREQ];
  tag_t            tag_q [RD_LATENCY];
  tag_t            tag_d [RD_LATENCY];
  tag_t            tag_out;
  req_id_t         winner, favour_q, favour_d;
  logic [WW-1:0]   win_q, win_d;
  logic            orphan_q, orphan_d;

  assign req_v   = {t1_valid, t0_valid};
  assign req_we  = {t1_we, t0_we};
  assign rsp_rdy = {i1_ready, i0_ready};

  assign t0_ready   = grant[0];
  assign t1_ready   = grant[1];
  assign i0_valid   = rsp_v[0];
  assign i1_valid   = rsp_v[1];
  assign i0_data    = rsp_d[0];
  assign i1_data    = rsp_d[1];
  assign err_orphan = orphan_q;
  assign pop        = rsp_v & rsp_rdy;
  assign tag_out    = tag_q[RD_LATENCY-1];

  // Eligibility and round-robin grant; reads need credit.
  always_comb begin
    for (int n = 0; n < NREQ; n++) begin
      elig[n] = req_v[n] &&
                (req_we[n] || credit_q[n] < CRED_MAX);
    end
    winner   = rr_pick(elig, favour_q);
    grant    = '0;
    favour_d = favour_q;
    if (m_t_ready && !srst && (|elig)) begin
      grant[winner] = 1'b1;
      favour_d      = ~winner;
    end
  end

  // Forward the winner's command fields unmodified.
  always_comb begin
    m_t_valid = |grant;
    m_t_we    = winner[0] ? t1_we   : t0_we;
    m_t_mask  = winner[0] ? t1_mask : t0_mask;
    m_t_addr  = winner[0] ? t1_addr : t0_addr;
    m_t_data  = winner[0] ? t1_data : t0_data;
  end

  // Tag pipeline tracks read ownership through memory latency.
  always_comb begin
    tag_d[0].rd = m_t_valid && !m_t_we;
    tag_d[0].id = winner;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Route responses; untagged ones flag an orphan after the window.
  always_comb begin
    push = '0;
    if (m_i_valid && tag_out.rd) begin
      push[tag_out.id] = 1'b1;
    end
    orphan_d = orphan_q ||
               (m_i_valid && !tag_out.rd && win_q == '0);
    win_d = (win_q != '0) ? win_q - 1'b1 : win_q;
  end

  // Credit = reads outstanding plus responses still queued.
  always_comb begin
    for (int n = 0; n < NREQ; n++) begin
      credit_d[n] = credit_q[n];
      unique case ({grant[n] && !req_we[n], pop[n]})
        2'b10:   credit_d[n] = credit_q[n] + 1'b1;
        2'b01:   credit_d[n] = credit_q[n] - 1'b1;
        default: credit_d[n] = credit_q[n];
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int n = 0; n < NREQ; n++) begin
        credit_q[n] <= '0;
      end
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= TAG_IDLE;
      end
      favour_q <= '0;
      win_q    <= WIN_INIT;
      orphan_q <= 1'b0;
    end else begin
      for (int n = 0; n < NREQ; n++) begin
        credit_q[n] <= credit_d[n];
      end
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
      favour_q <= favour_d;
      win_q    <= win_d;
      orphan_q <= orphan_d;
    end
  end

  // Queued responses can never exceed held credit.
  always_ff @(posedge clk) begin
    if (!srst) begin
      for (int n = 0; n < NREQ; n++) begin
        assert (fifo_cnt[n] <= credit_q[n]);
      end
    end
  end

  for (genvar n = 0; n < NREQ; n++) begin : g_fifo
    scalar_arb_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (32)
    ) u_fifo (
      .clk   (clk),
      .srst  (srst),
      .push  (push[n]),
      .wdata (m_i_data),
      .pop   (pop[n]),
      .valid (rsp_v[n]),
      .rdata (rsp_d[n]),
      .count (fifo_cnt[n])
    );
  end

endmodule

// File: tb/tb_scalar_mem_arbiter.sv
// tb_scalar_mem_arbiter: random traffic against a queue-based
// reference model, plus directed reset and orphan checks.
module tb_scalar_mem_arbiter;

  logic        clk = 1'b0;
  logic        srst;
  logic        t0_valid, t1_valid, t0_ready, t1_ready;
  logic        t0_we, t1_we;
  logic [3:0]  t0_mask, t1_mask;
  logic [31:0] t0_addr, t1_addr, t0_data, t1_data;
  logic        i0_valid, i1_valid;
  logic [31:0] i0_data, i1_data;
  logic        m_t_valid, m_t_ready, m_t_we;
  logic [3:0]  m_t_mask;
  logic [31:0] m_t_addr, m_t_data;
  logic        m_i_valid;
  logic [31:0] m_i_data;
  logic        err_orphan;

  logic [1:0]  cv, cwe, irdy, gl;
  logic [3:0]  cmask [2];
  logic [31:0] caddr [2];
  logic [31:0] cdata [2];

  typedef struct {
    logic [31:0] d;
    int          rdy;
  } resp_t;

  logic [31:0] mem [16];
  resp_t       rq [2][$];
  int          cr [2];
  int          prio;
  int          cyc;
  logic        mresp_v;
  logic [31:0] mresp_d;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign t0_valid = cv[0];
  assign t1_valid = cv[1];
  assign t0_we    = cwe[0];
  assign t1_we    = cwe[1];
  assign t0_mask  = cmask[0];
  assign t1_mask  = cmask[1];
  assign t0_addr  = caddr[0];
  assign t1_addr  = caddr[1];
  assign t0_data  = cdata[0];
  assign t1_data  = cdata[1];

  scalar_mem_arbiter #(
    .AWIDTH     (32),
    .RD_LATENCY (1),
    .RESP_DEPTH (4)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .t0_valid   (t0_valid),
    .t0_ready   (t0_ready),
    .t0_we      (t0_we),
    .t0_mask    (t0_mask),
    .t0_addr    (t0_addr),
    .t0_data    (t0_data),
    .t1_valid   (t1_valid),
    .t1_ready   (t1_ready),
    .t1_we      (t1_we),
    .t1_mask    (t1_mask),
    .t1_addr    (t1_addr),
    .t1_data    (t1_data),
    .i0_valid   (i0_valid),
    .i0_ready   (irdy[0]),
    .i0_data    (i0_data),
    .i1_valid   (i1_valid),
    .i1_ready   (irdy[1]),
    .i1_data    (i1_data),
    .m_t_valid  (m_t_valid),
    .m_t_ready  (m_t_ready),
    .m_t_we     (m_t_we),
    .m_t_mask   (m_t_mask),
    .m_t_addr   (m_t_addr),
    .m_t_data   (m_t_data),
    .m_i_valid  (m_i_valid),
    .m_i_data   (m_i_data),
    .err_orphan (err_orphan)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cr[0] = 0;
    cr[1] = 0;
    rq[0].delete();
    rq[1].delete();
    prio    = 0;
    gl      = '0;
    mresp_v = 1'b0;
  endtask

  // Checks one cycle at the negedge and advances the model.
  task automatic eval();
    logic [1:0]  el;
    logic [1:0]  iv;
    logic [31:0] idat [2];
    logic        expv;
    int          win;
    int          w;
    @(negedge clk);
    iv      = {i1_valid, i0_valid};
    idat[0] = i0_data;
    idat[1] = i1_data;
    for (int n = 0; n < 2; n++)
      el[n] = cv[n] && (cwe[n] || cr[n] < 4);
    win = -1;
    if (m_t_ready && el != 2'b00)
      win = (el == 2'b11) ? prio : (el[1] ? 1 : 0);
    chk("t0_ready", t0_ready, win == 0);
    chk("t1_ready", t1_ready, win == 1);
    chk("m_t_valid", m_t_valid, win >= 0);
    chk("err_orphan", err_orphan, 0);
    if (win >= 0) begin
      chk("m_t_we", m_t_we, cwe[win]);
      chk("m_t_mask", m_t_mask, cmask[win]);
      chk("m_t_addr", m_t_addr, caddr[win]);
      chk("m_t_data", m_t_data, cdata[win]);
    end
    for (int n = 0; n < 2; n++) begin
      expv = rq[n].size() > 0 && rq[n][0].rdy <= cyc;
      chk($sformatf("i%0d_valid", n), iv[n], expv);
      if (expv) begin
        chk($sformatf("i%0d_data", n), idat[n], rq[n][0].d);
        if (irdy[n]) begin
          void'(rq[n].pop_front());
          cr[n]--;
        end
      end
    end
    gl = '0;
    if (win >= 0) begin
      gl[win] = 1'b1;
      prio    = 1 - win;
      w       = int'(caddr[win][5:2]);
      if (cwe[win]) begin
        for (int b = 0; b < 4; b++)
          if (cmask[win][b])
            mem[w][8*b +: 8] = cdata[win][8*b +: 8];
      end else begin
        cr[win]++;
        rq[win].push_back('{d: mem[w], rdy: cyc + 2});
        mresp_v = 1'b1;
        mresp_d = mem[w];
      end
    end
  endtask

  task automatic step(input int vp, input int ip, input int mp);
    @(posedge clk);
    #1;
    cyc++;
    m_i_valid = mresp_v;
    m_i_data  = mresp_d;
    mresp_v   = 1'b0;
    for (int n = 0; n < 2; n++) begin
      if (!cv[n] || gl[n]) begin
        cv[n]    = ($urandom_range(99) < vp);
        cwe[n]   = ($urandom_range(2) == 0);
        cmask[n] = 4'($urandom);
        caddr[n] = {26'd0, 4'($urandom), 2'b00};
        cdata[n] = $urandom;
      end
      irdy[n] = ($urandom_range(99) < ip);
    end
    m_t_ready = ($urandom_range(99) < mp);
    eval();
  endtask

  initial begin
    srst      = 1'b1;
    cv        = '0;
    cwe       = '0;
    irdy      = '0;
    m_t_ready = 1'b1;
    m_i_valid = 1'b0;
    m_i_data  = '0;
    cyc       = 0;
    for (int n = 0; n < 2; n++) begin
      cmask[n] = '0;
      caddr[n] = '0;
      cdata[n] = '0;
    end
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_t_ready", {t1_ready, t0_ready}, 0);
    chk("rst_i_valid", {i1_valid, i0_valid}, 0);
    chk("rst_m_t_valid", m_t_valid, 0);
    chk("rst_err", err_orphan, 0);
    @(posedge clk);
    #1 srst = 1'b0;

    for (int k = 0; k < 400; k++) step(70, 80, 80);
    for (int k = 0; k < 400; k++) step(85, 15, 90);
    for (int k = 0; k < 200; k++) step(95, 100, 100);
    for (int k = 0; k < 30; k++)  step(0, 100, 100);

    // One read in flight, then reset while it returns.
    @(posedge clk);
    #1;
    m_i_valid = mresp_v;
    m_i_data  = mresp_d;
    cv        = 2'b01;
    cwe       = 2'b00;
    caddr[0]  = 32'h10;
    irdy      = 2'b11;
    m_t_ready = 1'b1;
    @(negedge clk);
    chk("inflight_grant", t0_ready, 1);
    @(posedge clk);
    #1;
    cv        = '0;
    srst      = 1'b1;
    m_i_valid = 1'b1;
    m_i_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("srst_t_ready", {t1_ready, t0_ready, m_t_valid}, 0);
    @(posedge clk);
    #1;
    srst      = 1'b0;
    m_i_data  = 32'hBAD1_BAD1;
    @(negedge clk);
    chk("win_i0_valid", i0_valid, 0);
    chk("win_err", err_orphan, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 m_i_valid = 1'b0;
      @(negedge clk);
      chk("post_i_valid", {i1_valid, i0_valid}, 0);
      chk("post_err", err_orphan, 0);
    end
    @(posedge clk);
    #1 m_i_valid = 1'b1;
    @(negedge clk);
    chk("orphan_pre", err_orphan, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 m_i_valid = 1'b0;
      @(negedge clk);
      chk("orphan_sticky", err_orphan, 1);
      chk("orphan_no_rsp", {i1_valid, i0_valid}, 0);
    end
    @(posedge clk);
    #1 srst = 1'b1;
    @(posedge clk);
    #1 srst = 1'b0;
    model_reset();
    cyc++;
    cv        = 2'b11;
    cwe       = 2'b00;
    caddr[0]  = 32'h0;
    caddr[1]  = 32'h4;
    irdy      = 2'b11;
    m_t_ready = 1'b1;
    eval();
    chk("rr_after_rst", {t1_ready, t0_ready}, 2'b01);
    for (int k = 0; k < 150; k++) step(80, 60, 85);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scalar_mem_arbiter.md
Name: scalar_mem_arbiter

Overview:
Shares one port of the scalar memory between two requesters, for example the scalar core load/store unit and the DMA/debug path.
- Arbitration is round-robin; each request is forwarded as one command per cycle.
- Read-response ownership is tracked through the fixed memory read latency.
- Read data is returned through per-requester response FIFOs, because the memory's response valid ignores ready.
- A read is granted only while the requester holds response credit, so data can never be dropped.

Parameters:
- AWIDTH, 32, byte-address width forwarded to memory.
- RD_LATENCY, 1, cycles from memory command accept to memory response valid (must be 1 or more).
- RESP_DEPTH, 4, entries per requester response FIFO; also the credit limit.

Ports:
- clk  in  1  clock
- srst  in  1  synchronous active-high reset
- t0_valid / t1_valid  in  1  requester command valid
- t0_ready / t1_ready  out  1  command granted this cycle
- t0_we / t1_we  in  1  1 = write, 0 = read
- t0_mask / t1_mask  in  4  byte-lane write enables
- t0_addr / t1_addr  in  AWIDTH  byte address
- t0_data / t1_data  in  32  write data
- i0_valid / i1_valid  out  1  read response available
- i0_ready / i1_ready  in  1  requester accepts response
- i0_data / i1_data  out  32  read response data
- m_t_valid  out  1  command to memory
- m_t_ready  in  1  memory accepts command
- m_t_we  out  1  forwarded write flag
- m_t_mask  out  4  forwarded byte mask
- m_t_addr  out  AWIDTH  forwarded address
- m_t_data  out  32  forwarded write data
- m_i_valid  in  1  memory read response valid (no backpressure)
- m_i_data  in  32  memory read response data
- err_orphan  out  1  sticky: response arrived with no matching tag

Behaviour:
Reset:
- When srst=1 at a clock edge: all tx_ready, ix_valid and m_t_valid are 0; err_orphan is 0.
- Credits, FIFOs and the tag pipeline are cleared; the round-robin pointer favours r0 next.
- In-flight reads are abandoned.
- Reset mid-operation: any m_i_valid in the first RD_LATENCY cycles after srst deasserts is dropped silently and does not set err_orphan.

Eligibility and grant (combinational, same cycle):
- Requester n is eligible when tn_valid=1 and either tn_we=1, or credit_n < RESP_DEPTH.
- Grant requires m_t_ready=1.
- One eligible requester: it is granted.
- Both eligible: the requester other than the last granted one wins. The pointer updates only on a grant.
- tn_ready = grant_n. The m_t_* fields are muxed from the winner; m_t_valid = grant_0 | grant_1.
- A requester's valid must not depend on its ready. A stalled requester must hold its command stable.
- Writes are forwarded unmodified and generate no response. Masks pass through even when they are 0.

Credits:
- credit_n (range 0..RESP_DEPTH) increments on a granted read from n.
- It decrements on in_valid & in_ready.
- Increment and decrement in the same cycle leave it unchanged.
- A read is never granted at credit_n = RESP_DEPTH; the write path is unaffected.

Tag pipeline:
- A RD_LATENCY-deep shift register of {rd, id}. It is loaded with {~m_t_we & m_t_valid, winner} at each cycle and shifts every cycle.
- At the output, m_i_valid with rd=1 pushes m_i_data into FIFO[id].
- m_i_valid with rd=0 (outside the post-reset window) sets err_orphan and drops the data.
- rd=1 without m_i_valid is ignored; the credit stays held. This is a memory fault and is not recovered.

Response FIFO (per requester):
- Show-ahead: in_valid = !empty, in_data = head.
- Push and pop in the same cycle are legal at any occupancy.
- There is no bypass: a push into an empty FIFO is visible the next cycle.
- Overflow is impossible by construction; verification asserts this.
- Read latency with an empty FIFO: grant at cycle N, m_i_valid at N+RD_LATENCY, in_valid at N+RD_LATENCY+1.
- Responses return in request order per requester.

Decomposition:
- Package scalar_arb_pkg holds NREQ=2, REQ_ID_W=1, and the tag record type {rd, id}.
- Sub-module scalar_arb_resp_fifo: parameterised 32-bit show-ahead FIFO with count output, instantiated once per requester.
- Arbitration, credits and the tag pipeline stay in the top module.

Test Plan:
1. Single read from r0 at addr 0x10, memory word = 0xDEADBEEF: t0_ready=1 at N, i0_valid=1 with i0_data=0xDEADBEEF at N+2 (RD_LATENCY=1), i1_valid stays 0.
2. Both requesters issue continuous reads, both with ready held 1: grants alternate r0,r1,r0,...; each side receives its own addresses' data in order.
3. r0 reads with i0_ready=0: exactly 4 grants, then t0_ready=0 while r1 reads continue. Raising i0_ready for one cycle pops one entry and allows exactly one more r0 grant.
4. r0 writes 0x11223344 with mask 4'b0101 to 0x20 while r1 reads 0x20 next cycle: write forwarded unmodified, no i0 response, r1 read data reflects the written lanes.
5. m_t_ready=0 for 3 cycles with both requesters valid: no tx_ready, pointer unchanged; the first grant after m_t_ready=1 goes to the pointer-favoured requester.
6. Assert srst while 1 read is in flight: i0_valid stays 0, stale m_i_valid is dropped, err_orphan=0. An injected orphan m_i_valid 5 cycles later sets err_orphan=1, which holds until srst.
